// File: rtl/cfg_shift_reg.sv
// Serial 3-wire (SCK/CSN/SDI) configuration register sampled on the core clock.
// Define CFG_READBACK_EN to enable SDO readback of the configuration word on read frames.
module cfg_shift_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             CSN,
    input  logic             SDI,
    output logic             SDO,
    output logic [WIDTH-1:0] CFG,
    output logic             CFG_VLD,
    output logic             BUSY,
    output logic             ERR
);

    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       sckSync_q;
    logic [2:0]       csnSync_q;
    logic [1:0]       sdiSync_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] cfg_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             isWrite_q;
    logic             cfgVld_q;
    logic             busy_q;
    logic             err_q;
    logic             sckRise;
    logic             csnFall;
    logic             csnRise;
`ifdef CFG_READBACK_EN
    logic             sckFall;
    logic             sdo_q;
`endif

    // Sync flops clear to 0 so a frame left open across reset never shows a CSN fall.
    always_ff @(posedge CK) begin
        if (RST) begin
            sckSync_q <= '0;
            csnSync_q <= '0;
            sdiSync_q <= '0;
        end else begin
            sckSync_q <= {sckSync_q[1:0], SCK};
            csnSync_q <= {csnSync_q[1:0], CSN};
            sdiSync_q <= {sdiSync_q[0], SDI};
        end
    end

    assign sckRise =  sckSync_q[1] & ~sckSync_q[2];
    assign csnFall = ~csnSync_q[1] &  csnSync_q[2];
    assign csnRise =  csnSync_q[1] & ~csnSync_q[2];
`ifdef CFG_READBACK_EN
    assign sckFall = ~sckSync_q[1] &  sckSync_q[2];
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A CSN rise always takes priority over an SCK edge seen in the same cycle.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            isWrite_q <= 1'b0;
            cfg_q     <= RST_VAL;
            cfgVld_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CFG_READBACK_EN
            sdo_q     <= 1'b0;
`endif
        end else begin
            cfgVld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (csnFall) begin
                        state_q   <= CMD;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        isWrite_q <= 1'b0;
                    end
                end
                CMD: begin
                    if (csnRise) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                    end else if (sckRise) begin
                        state_q   <= DATA;
                        isWrite_q <= sdiSync_q[1];
                        cnt_q     <= '0;
`ifdef CFG_READBACK_EN
                        if (!sdiSync_q[1]) begin
                            sr_q <= cfg_q;
                        end
`endif
                    end
                end
                DATA: begin
                    if (csnRise) begin
                        state_q <= DONE;
                        err_q   <= (cnt_q != CNT_FULL);
                        if (isWrite_q && (cnt_q == CNT_FULL)) begin
                            cfg_q    <= sr_q;
                            cfgVld_q <= 1'b1;
                        end
`ifdef CFG_READBACK_EN
                        sdo_q <= 1'b0;
`endif
                    end else if (sckRise) begin
                        cnt_q <= cnt_d;
                        if (isWrite_q) begin
                            sr_q <= {sr_q[WIDTH-2:0], sdiSync_q[1]};
                        end
                    end
`ifdef CFG_READBACK_EN
                    // Readback shifts on falls so the host sees each bit stable at its SCK rise.
                    else if (sckFall && !isWrite_q) begin
                        sdo_q <= sr_q[WIDTH-1];
                        sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign CFG     = cfg_q;
    assign CFG_VLD = cfgVld_q;
    assign BUSY    = busy_q;
    assign ERR     = err_q;
`ifdef CFG_READBACK_EN
    assign SDO     = sdo_q;
`else
    assign SDO     = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_shift_reg.sv
// Randomized self-checking bench for cfg_shift_reg against a frame-level reference model.
module tb_cfg_shift_reg;

    localparam int WIDTH = 16;
`ifdef CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic             CK = 1'b0;
    logic             RST;
    logic             SCK;
    logic             CSN;
    logic             SDI;
    logic             SDO;
    logic [WIDTH-1:0] CFG;
    logic             CFG_VLD;
    logic             BUSY;
    logic             ERR;

    int               checks   = 0;
    int               errors   = 0;
    int               vldTotal = 0;
    logic [WIDTH-1:0] cfgModel;
    logic             errModel;

    always #5 CK = ~CK;

    cfg_shift_reg #(
        .WIDTH  (WIDTH),
        .RST_VAL(16'h0000)
    ) dut (
        .CK     (CK),
        .RST    (RST),
        .SCK    (SCK),
        .CSN    (CSN),
        .SDI    (SDI),
        .SDO    (SDO),
        .CFG    (CFG),
        .CFG_VLD(CFG_VLD),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    always @(negedge CK) begin
        if (CFG_VLD === 1'b1) vldTotal++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic waitCk(input int n);
        repeat (n) @(posedge CK);
        #2;
    endtask

    task automatic openFrame();
        CSN = 1'b0;
        waitCk(6);
        checkOutput("busy_open", {63'd0, BUSY}, 64'd1);
    endtask

    // One SCK period; SDO is sampled just before the rise, as the host would.
    task automatic clockBit(input logic b, output logic sdoSample, input bit closeWithRise);
        SDI = b;
        waitCk(6);
        sdoSample = SDO;
        SCK = 1'b1;
        if (closeWithRise) CSN = 1'b1;
        waitCk(6);
        SCK = 1'b0;
        waitCk(6);
    endtask

    task automatic applyStimulus(input bit w, input logic [WIDTH-1:0] data, input int nbits,
                                 input bit noCmd, input bit simul);
        int               vldBefore;
        int               eff;
        logic [WIDTH-1:0] rdata;
        logic [WIDTH-1:0] cfgBefore;
        logic             s;
        logic             b;
        vldBefore = vldTotal;
        cfgBefore = cfgModel;
        rdata     = '0;
        openFrame();
        if (!noCmd) begin
            clockBit(w, s, simul && (nbits == 0));
            for (int j = 0; j < nbits; j++) begin
                b = (j < WIDTH) ? data[WIDTH-1-j] : 1'($urandom_range(0, 1));
                clockBit(b, s, simul && (j == nbits - 1));
                if (j < WIDTH) rdata = {rdata[WIDTH-2:0], s};
            end
        end
        if (noCmd || !simul) CSN = 1'b1;
        waitCk(12);

        eff = noCmd ? -1 : (simul ? nbits - 1 : nbits);
        if (eff == WIDTH) begin
            errModel = 1'b0;
            if (w) cfgModel = data;
        end else begin
            errModel = 1'b1;
        end

        checkOutput("cfg", {48'd0, CFG}, {48'd0, cfgModel});
        checkOutput("err", {63'd0, ERR}, {63'd0, errModel});
        checkOutput("busy_idle", {63'd0, BUSY}, 64'd0);
        checkOutput("sdo_idle", {63'd0, SDO}, 64'd0);
        checkOutput("vld_pulses", 64'(vldTotal - vldBefore), (w && eff == WIDTH) ? 64'd1 : 64'd0);
        if (!w && !noCmd && !simul && nbits == WIDTH)
            checkOutput("readback", {48'd0, rdata}, READBACK ? {48'd0, cfgBefore} : 64'd0);
    endtask

    initial begin
        logic s;
        RST = 1'b1;
        SCK = 1'b0;
        CSN = 1'b1;
        SDI = 1'b0;
        cfgModel = 16'h0000;
        errModel = 1'b0;
        waitCk(2);
        RST = 1'b0;
        waitCk(1);
        checkOutput("rst_cfg", {48'd0, CFG}, 64'd0);
        checkOutput("rst_busy", {63'd0, BUSY}, 64'd0);
        checkOutput("rst_err", {63'd0, ERR}, 64'd0);
        checkOutput("rst_sdo", {63'd0, SDO}, 64'd0);
        checkOutput("rst_vld", {63'd0, CFG_VLD}, 64'd0);
        waitCk(5);

        applyStimulus(1'b1, 16'hA5C3, 16, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 15, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16, 1'b0, 1'b0);

        // Reset in the middle of a write frame while CSN stays low.
        openFrame();
        clockBit(1'b1, s, 1'b0);
        for (int j = 0; j < 8; j++) clockBit(1'b1, s, 1'b0);
        RST = 1'b1;
        waitCk(2);
        RST = 1'b0;
        waitCk(1);
        cfgModel = 16'h0000;
        errModel = 1'b0;
        checkOutput("midrst_cfg", {48'd0, CFG}, 64'd0);
        checkOutput("midrst_busy", {63'd0, BUSY}, 64'd0);
        begin
            int vldBefore;
            vldBefore = vldTotal;
            waitCk(4);
            CSN = 1'b1;
            waitCk(12);
            checkOutput("midrst_vld", 64'(vldTotal - vldBefore), 64'd0);
            checkOutput("midrst_err", {63'd0, ERR}, 64'd0);
            checkOutput("midrst_busy2", {63'd0, BUSY}, 64'd0);
        end

        applyStimulus(1'b1, 16'h00FF, 16, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 16, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h5555, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h3C3C, 17, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h3C3C, 16, 1'b0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            bit               w;
            bit               noCmd;
            bit               simul;
            int               nbits;
            logic [WIDTH-1:0] data;
            w     = 1'($urandom_range(0, 1));
            data  = WIDTH'($urandom());
            nbits = ($urandom_range(0, 9) < 6) ? WIDTH : int'($urandom_range(0, 18));
            noCmd = ($urandom_range(0, 15) == 0);
            simul = !noCmd && ($urandom_range(0, 7) == 0);
            applyStimulus(w, data, nbits, noCmd, simul);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_shift_reg.md
# cfg_shift_reg

Serial configuration register for KISTA SOI test chips. It receives a 3-wire serial frame (SCK/CSN/SDI) from the pad ring and samples it on the core clock. Valid write frames update a parallel WIDTH-bit configuration word that drives the on-chip analog and digital control bits. Optional readback returns the current word on SDO. The block maps onto the KISTA standard-cell library: DFFX1 flops, MX2X1 muxes, NAND/NOR glue and TIEHI/TIELO ties.

## Interface
Parameters:
- WIDTH, 16: configuration word width; legal range 4–64.
- RST_VAL, {WIDTH{1'b0}}: value loaded into CFG at reset.

Ports:
- CK  input  1  core clock; all flops are rising-edge.
- RST  input  1  reset; synchronous, active-high.
- SCK  input  1  serial clock from pad; asynchronous to CK.
- CSN  input  1  frame select, active-low; asynchronous to CK.
- SDI  input  1  serial data in, MSB first; asynchronous to CK.
- SDO  output  1  serial readback data.
- CFG  output  WIDTH  configuration word.
- CFG_VLD  output  1  one-CK pulse when CFG is updated.
- BUSY  output  1  high while a frame is open.
- ERR  output  1  sticky frame-error flag.

## Operation
- SCK, CSN and SDI each pass through a 2-flop synchronizer. A third flop on SCK and on CSN provides edge detection.
- Frame format: 1 command bit W (1 = write, 0 = read), then WIDTH data bits, MSB first. SDI is sampled on detected SCK rising edges.
- FSM states and transitions:
  - IDLE: on a CSN falling edge, go to CMD and set BUSY=1.
  - CMD: on the first SCK rise, latch W, clear the bit counter and go to DATA.
  - DATA: each SCK rise shifts SDI into shift register SR and increments the counter. The counter saturates at WIDTH+1.
  - DONE: entered on a CSN rising edge from CMD or DATA. It lasts exactly one cycle, then returns to IDLE.
- Evaluation in DONE:
  - Write frame with counter==WIDTH: CFG<=SR, CFG_VLD=1, ERR<=0.
  - Write frame with any other count: CFG is unchanged and ERR<=1.
  - Read frame: CFG is unchanged. ERR<=0 if counter==WIDTH, else ERR<=1.
  - CSN rising while still in CMD (zero SCK edges): ERR<=1.
- Readback: on a read frame, SR is loaded with CFG at the SCK rise that captures W. SDO presents SR[WIDTH-1] and SR shifts left on each SCK falling edge. The host samples SDO on SCK rising edges. SDO=0 whenever BUSY=0 or the frame is a write.
- Simultaneous events: if a CSN rising edge and an SCK rising edge are detected in the same CK cycle, CSN wins and the SCK edge is ignored.
- Counter width: clog2(WIDTH+2) bits.
- Reset (including mid-frame): FSM<=IDLE, SR<=0, counter<=0, CFG<=RST_VAL, CFG_VLD=0, BUSY=0, ERR=0, SDO=0. The partial frame is discarded. Pins are sampled normally from the first cycle after RST deasserts. A frame that is already open with CSN low is ignored until CSN goes high and then low again.

## Timing
- Pin-to-detect latency: 3 CK cycles from an SCK or CSN pin transition to the internal edge strobe.
- SCK high and low phases must each be ≥4 CK periods. CSN setup to the first SCK rise and hold after the last SCK rise must each be ≥4 CK periods. SDI must be stable ≥4 CK periods around each SCK rise.
- CFG and CFG_VLD change in the DONE cycle, 4 CK cycles after the CSN rising pin edge. CFG_VLD is high for exactly 1 cycle.
- SDO is valid 4 CK cycles after the SCK falling pin edge.
- BUSY rises 4 CK cycles after the CSN falling pin edge and falls when DONE exits to IDLE.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Configuration
- CFG_READBACK_EN defined: read frames load SR from CFG and drive SDO as described in Operation.
- CFG_READBACK_EN undefined:
  - SDO is tied to 0 with TIELO and the readback mux and falling-edge detector are removed.
  - Read frames are still counted and checked: ERR behaves identically, and CFG is never changed by a read frame.

## Test plan
All scenarios use WIDTH=16 and RST_VAL=16'h0000.
- Reset check: RST high for 2 cycles → CFG=16'h0000, BUSY=0, ERR=0, SDO=0, CFG_VLD=0.
- Write frame W=1, data 16'hA5C3 → CFG=16'hA5C3, one CFG_VLD pulse, ERR=0, BUSY low after DONE.
- Write frame with only 15 data bits of 16'h1234 → CFG stays 16'hA5C3, ERR=1, no CFG_VLD pulse. A following valid write of 16'h00FF sets CFG=16'h00FF and clears ERR.
- Read frame after CFG=16'h00FF (CFG_READBACK_EN defined) → 16 SDO bits sampled on SCK rises equal 16'h00FF MSB first, CFG unchanged, ERR=0. With the macro undefined, SDO stays 0 throughout.
- RST asserted after 8 data bits of a write frame → CFG=16'h0000, FSM in IDLE. Releasing CSN produces no CFG_VLD and ERR=0.
- CSN rising in the same CK cycle as the 17th SCK rise edge strobe → that edge is ignored, count=15, ERR=1, CFG unchanged.
